pio_access_arbiter: RTL and testbench

Round-robin arbiter that shares one Avalon-MM PIO slave port (the green-LED PIO `s1`: 2-bit address, chipselect, write_n, 32-bit writedata/readdata) between several on-chip requesters, e.g. the PCI host bridge and the game-effect sequencer. It serialises their single-beat read/write requests into one PIO access at a time. It returns read data or a write acknowledge to the granted requester. It sits between the requesters and the PIO slave inside the core.

---
 rtl/pio_access_arbiter.sv | 142 ++++++++++++++
 tb/tb_pio_access_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_access_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM PIO slave port.
// Serialises single-beat requests into ISSUE/RESP access pairs.
module pio_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic [ADDR_W-1:0]         pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [DATA_W-1:0]         pio_writedata,
  input  logic [DATA_W-1:0]         pio_readdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NQ = (IW+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]      r_last;
  logic [IW-1:0]      r_gid;
  logic               r_write;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;

  logic                 w_any;
  logic                 w_grant;
  logic [IW:0]          w_sh;
  logic [IW:0]          w_sum;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [IW-1:0]        w_off;
  logic [IW-1:0]        w_win;
  logic [NUM_REQ-1:0]   w_onehot;

  // Round-robin pick: rotate requests so the slot after the
  // last grant sits at bit 0, take the lowest set bit, unrotate.
  always_comb begin
    w_any = |req_valid;
    w_sh  = {1'b0, r_last} + (IW+1)'(1);
    w_rot = {req_valid, req_valid} >> w_sh;
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
    w_sum = w_sh + {1'b0, w_off};
    if (w_sum >= NQ) w_win = IW'(w_sum - NQ);
    else             w_win = IW'(w_sum);
  end

  assign w_onehot       = ONE << r_gid;
  assign pio_address    = r_addr;
  assign pio_writedata  = r_wdata;
  assign rsp_rdata      = r_rdata;
  assign grant_id       = 3'(r_gid);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and per-state strobes.
  always_comb begin
    w_next         = r_state;
    w_grant        = 1'b0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    req_ready      = '0;
    rsp_valid      = '0;
    busy           = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy           = 1'b1;
        pio_chipselect = 1'b1;
        pio_write_n    = ~r_write;
        req_ready      = w_onehot;
        w_next         = S_RESP;
      end
      S_RESP: begin
        busy      = 1'b1;
        rsp_valid = w_onehot;
        if (w_any) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
        end else begin
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch winner payload on grant; capture read data in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= IW'(NUM_REQ - 1);
      r_gid   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_last  <= w_win;
        r_gid   <= w_win;
        r_write <= req_write[w_win];
        r_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
        r_wdata <= req_wdata[w_win*DATA_W +: DATA_W];
      end
      if (r_state == S_ISSUE) begin
        r_rdata <= r_write ? '0 : pio_readdata;
      end
    end
  end

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Scoreboard bench for pio_access_arbiter with a small PIO model.
// Expected responses are queued at stimulus time, popped on RESP.
module tb_pio_access_arbiter;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [2:0]      grant_id;
  logic            busy;
  logic [AW-1:0]   pio_address;
  logic            pio_chipselect;
  logic            pio_write_n;
  logic [DW-1:0]   pio_writedata;
  logic [DW-1:0]   pio_readdata;

  logic [DW-1:0]   out_port = '0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pio_access_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .grant_id       (grant_id),
    .busy           (busy),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata)
  );

  // Green-LED PIO model: register at offset 0, other offsets read 0.
  assign pio_readdata = (pio_address == 2'd0) ? out_port : '0;
  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n && pio_address == 2'd0)
      out_port <= pio_writedata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic wr,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[id]          = 1'b1;
    req_write[id]          = wr;
    req_addr[id*AW +: AW]  = a;
    req_wdata[id*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    do_reset();
    n_tests++;
    if ({pio_chipselect, pio_write_n, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_ctrl got cs/wn/busy=%b want 010",
               {pio_chipselect, pio_write_n, busy});
    end
    n_tests++;
    if (pio_address !== '0 || pio_writedata !== '0) begin
      n_fail++;
      $display("FAIL reset_bus got addr=%0h wd=%0h want 0",
               pio_address, pio_writedata);
    end
    n_tests++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_rdata !== '0
        || grant_id !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp got rdy=%b rv=%b rd=%0h gid=%0d want 0",
               req_ready, rsp_valid, rsp_rdata, grant_id);
    end
  endtask

  task automatic test_single_write();
    exp_t e;
    set_req(2, 1'b1, 2'd0, 32'h0000_00FF);
    sb.push_back('{2, 32'h0});
    tick();
    n_tests++;
    if ({pio_chipselect, pio_write_n} !== 2'b10 || req_ready !== 4'b0100
        || pio_writedata !== 32'hFF || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_issue got cs=%b wn=%b rdy=%b wd=%0h busy=%b",
               pio_chipselect, pio_write_n, req_ready, pio_writedata, busy);
    end
    req_valid = '0;
    tick();
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL wr_rsp scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== (4'b1 << e.id) || rsp_rdata !== e.data
          || pio_chipselect !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_rsp got rv=%b rd=%0h cs=%b want rv=%b rd=%0h",
                 rsp_valid, rsp_rdata, pio_chipselect,
                 4'b1 << e.id, e.data);
      end
    end
    tick();
    n_tests++;
    if (out_port !== 32'hFF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_commit got port=%0h busy=%b want ff 0",
               out_port, busy);
    end
  endtask

  task automatic test_read_back();
    exp_t        e;
    logic [1:0]  adr [2] = '{2'd0, 2'd1};
    logic [31:0] exd [2] = '{32'hFF, 32'h0};
    for (int k = 0; k < 2; k++) begin
      set_req(0, 1'b0, adr[k], 32'h0);
      sb.push_back('{0, exd[k]});
      tick();
      n_tests++;
      if (req_ready !== 4'b0001 || pio_write_n !== 1'b1
          || pio_chipselect !== 1'b1) begin
        n_fail++;
        $display("FAIL rd_issue%0d got rdy=%b wn=%b cs=%b", k,
                 req_ready, pio_write_n, pio_chipselect);
      end
      req_valid = '0;
      tick();
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rd_rsp%0d scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== (4'b1 << e.id) || rsp_rdata !== e.data) begin
          n_fail++;
          $display("FAIL rd_rsp%0d got rv=%b rd=%0h want rv=%b rd=%0h",
                   k, rsp_valid, rsp_rdata, 4'b1 << e.id, e.data);
        end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int   g [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 2'd0, 32'h10 + i);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++)
      sb.push_back('{g[k], 32'h0});
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL cont_issue%0d scoreboard empty", k);
      end else if (req_ready !== (4'b1 << sb[0].id)
                   || grant_id !== 3'(sb[0].id)
                   || pio_chipselect !== 1'b1) begin
        n_fail++;
        $display("FAIL cont_issue%0d got rdy=%b gid=%0d cs=%b want id %0d",
                 k, req_ready, grant_id, pio_chipselect, sb[0].id);
      end
      if (k == 4) req_valid = '0;
      tick();
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL cont_rsp%0d scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== (4'b1 << e.id) || rsp_rdata !== e.data
            || pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin
          n_fail++;
          $display("FAIL cont_rsp%0d got rv=%b rd=%0h cs=%b wn=%b want rv=%b",
                   k, rsp_valid, rsp_rdata, pio_chipselect, pio_write_n,
                   4'b1 << e.id);
        end
      end
    end
    tick();
    n_tests++;
    if (out_port !== 32'h10 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_port got port=%0h busy=%b want 10 0",
               out_port, busy);
    end
  endtask

  task automatic test_fairness();
    exp_t e;
    do_reset();
    set_req(1, 1'b0, 2'd1, 32'h0);
    sb.push_back('{1, 32'h0});
    sb.push_back('{3, 32'h0});
    sb.push_back('{1, 32'h0});
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL fair_issue%0d scoreboard empty", k);
      end else if (req_ready !== (4'b1 << sb[0].id)) begin
        n_fail++;
        $display("FAIL fair_issue%0d got rdy=%b want %b",
                 k, req_ready, 4'b1 << sb[0].id);
      end
      if (k == 0) set_req(3, 1'b0, 2'd1, 32'h0);
      if (k == 1) req_valid[3] = 1'b0;
      if (k == 2) req_valid = '0;
      tick();
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL fair_rsp%0d scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== (4'b1 << e.id) || rsp_rdata !== e.data) begin
          n_fail++;
          $display("FAIL fair_rsp%0d got rv=%b rd=%0h want rv=%b",
                   k, rsp_valid, rsp_rdata, 4'b1 << e.id);
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    set_req(2, 1'b1, 2'd0, 32'h5A);
    tick();
    n_tests++;
    if (pio_chipselect !== 1'b1 || req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL rst_mid_issue got cs=%b rdy=%b want 1 0100",
               pio_chipselect, req_ready);
    end
    reset = 1'b1;
    set_req(0, 1'b0, 2'd0, 32'h0);
    tick();
    reset = 1'b0;
    n_tests++;
    if ({pio_chipselect, pio_write_n, busy} !== 3'b010
        || rsp_valid !== '0 || req_ready !== '0 || rsp_rdata !== '0
        || grant_id !== '0 || pio_address !== '0
        || pio_writedata !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_out got cs=%b wn=%b busy=%b rv=%b rdy=%b rd=%0h gid=%0d a=%0h wd=%0h",
               pio_chipselect, pio_write_n, busy, rsp_valid, req_ready,
               rsp_rdata, grant_id, pio_address, pio_writedata);
    end
    sb.push_back('{0, 32'h5A});
    tick();
    n_tests++;
    if (req_ready !== 4'b0001 || grant_id !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_regrant got rdy=%b gid=%0d want 0001 0",
               req_ready, grant_id);
    end
    req_valid = '0;
    tick();
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL rst_mid_rsp scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== (4'b1 << e.id) || rsp_rdata !== e.data) begin
        n_fail++;
        $display("FAIL rst_mid_rsp got rv=%b rd=%0h want rv=%b rd=%0h",
                 rsp_valid, rsp_rdata, 4'b1 << e.id, e.data);
      end
    end
    tick();
  endtask

  task automatic test_payload();
    exp_t e;
    set_req(1, 1'b1, 2'd2, 32'hA5A5_0001);
    sb.push_back('{1, 32'h0});
    tick();
    req_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
    req_addr[1*AW +: AW]  = 2'd0;
    #1;
    n_tests++;
    if (pio_writedata !== 32'hA5A5_0001 || pio_address !== 2'd2
        || pio_write_n !== 1'b0 || req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL payload_issue got wd=%0h a=%0d wn=%b rdy=%b want a5a50001 2 0 0010",
               pio_writedata, pio_address, pio_write_n, req_ready);
    end
    req_valid = '0;
    tick();
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL payload_rsp scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== (4'b1 << e.id) || rsp_rdata !== e.data) begin
        n_fail++;
        $display("FAIL payload_rsp got rv=%b rd=%0h want rv=%b rd=%0h",
                 rsp_valid, rsp_rdata, 4'b1 << e.id, e.data);
      end
    end
    tick();
    n_tests++;
    if (out_port !== 32'h5A) begin
      n_fail++;
      $display("FAIL payload_port got port=%0h want 5a", out_port);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_payload();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
